e203_ifu_predec_fifo: RTL and testbench

- Parametrised IFU pre-decode instruction buffer between the fetch datapath and the IFU-to-EXU interface.
- Each accepted instruction is pre-decoded at write time (rv32 / branch class / immediate / rs1 index) and stored with its PC.
- A static prediction (taken flag and next-PC) is computed and stored alongside, so the IFU reads prediction results from the head without re-decoding.
- Supports flush and configurable depth.

---
 rtl/e203_ifu_predec_fifo_pkg.sv | 26 ++
 rtl/e203_ifu_predec_core.sv | 72 +++++++
 rtl/e203_ifu_predec_fifo.sv | 141 ++++++++++++++
 tb/tb_e203_ifu_predec_fifo.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/e203_ifu_predec_fifo_pkg.sv
// Shared constants for the IFU pre-decode buffer: opcodes, RVC quadrants/funct3
// and the default widths used as parameter defaults.
package e203_ifu_predec_fifo_pkg;

  localparam int E203_PC_SIZE     = 32;
  localparam int E203_XLEN        = 32;
  localparam int E203_RFIDX_WIDTH = 5;

  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {
    RVC_Q0     = 2'b00,
    RVC_Q1     = 2'b01,
    RVC_Q2     = 2'b10,
    RV32_INSTR = 2'b11
  } quadrant_e;

  localparam logic [2:0] C_F3_JAL  = 3'b001;
  localparam logic [2:0] C_F3_J    = 3'b101;
  localparam logic [2:0] C_F3_BEQZ = 3'b110;
  localparam logic [2:0] C_F3_BNEZ = 3'b111;
  localparam logic [2:0] C_F3_JR   = 3'b100;

endpackage

// File: rtl/e203_ifu_predec_core.sv
// Combinational pre-decoder: branch/jump class, offset, jalr rs1 and static
// prediction (JAL taken, BTFN or not-taken for conditional branches).
module e203_ifu_predec_core
  import e203_ifu_predec_fifo_pkg::*;
#(
  parameter int PC_W     = E203_PC_SIZE,
  parameter int XLEN     = E203_XLEN,
  parameter int RFIDX_W  = E203_RFIDX_WIDTH,
  parameter int BXX_BTFN = 1
) (
  input  logic [31:0]        instr_i,
  input  logic [PC_W-1:0]    pc_i,
  output logic               rv32_o,
  output logic               jal_o,
  output logic               jalr_o,
  output logic               bxx_o,
  output logic [RFIDX_W-1:0] rs1idx_o,
  output logic [XLEN-1:0]    imm_o,
  output logic               prdt_taken_o,
  output logic [PC_W-1:0]    prdt_pc_o
);

  quadrant_e  quad;
  logic [6:0] opc;
  logic [2:0] c_f3;
  logic       c_jalr_ok;

  assign quad      = quadrant_e'(instr_i[1:0]);
  assign opc       = instr_i[6:0];
  assign c_f3      = instr_i[15:13];
  // C.JR/C.JALR need rs2 = 0 and rs1 != 0; otherwise the slot is C.MV/C.ADD/C.EBREAK.
  assign c_jalr_ok = (instr_i[6:2] == 5'd0) && (instr_i[11:7] != 5'd0);

  always_comb begin
    rv32_o   = (quad == RV32_INSTR);
    jal_o    = 1'b0;
    jalr_o   = 1'b0;
    bxx_o    = 1'b0;
    rs1idx_o = '0;
    imm_o    = '0;
    if (rv32_o) begin
      if (opc == OPC_JAL) begin
        jal_o = 1'b1;
        imm_o = {{(XLEN-20){instr_i[31]}}, instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};
      end else if (opc == OPC_JALR) begin
        jalr_o   = 1'b1;
        rs1idx_o = RFIDX_W'(instr_i[19:15]);
      end else if (opc == OPC_BRANCH) begin
        bxx_o = 1'b1;
        imm_o = {{(XLEN-12){instr_i[31]}}, instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
      end
    end else if (quad == RVC_Q1) begin
      if (c_f3 == C_F3_J || c_f3 == C_F3_JAL) begin
        jal_o = 1'b1;
        imm_o = {{(XLEN-11){instr_i[12]}}, instr_i[8], instr_i[10:9], instr_i[6], instr_i[7],
                 instr_i[2], instr_i[11], instr_i[5:3], 1'b0};
      end else if (c_f3 == C_F3_BEQZ || c_f3 == C_F3_BNEZ) begin
        bxx_o = 1'b1;
        imm_o = {{(XLEN-8){instr_i[12]}}, instr_i[6:5], instr_i[2], instr_i[11:10],
                 instr_i[4:3], 1'b0};
      end
    end else if (quad == RVC_Q2 && c_f3 == C_F3_JR && c_jalr_ok) begin
      jalr_o   = 1'b1;
      rs1idx_o = RFIDX_W'(instr_i[11:7]);
    end

    prdt_taken_o = jal_o | (bxx_o & (BXX_BTFN != 0) & imm_o[XLEN-1]);
    prdt_pc_o    = prdt_taken_o ? (pc_i + PC_W'(imm_o))
                                : (pc_i + (rv32_o ? PC_W'(4) : PC_W'(2)));
  end

endmodule

// File: rtl/e203_ifu_predec_fifo.sv
// IFU pre-decode instruction buffer: decodes at write, stores decode + prediction
// with the PC; head visible one edge after write, flush wins over read/write.
module e203_ifu_predec_fifo
  import e203_ifu_predec_fifo_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int PC_W     = E203_PC_SIZE,
  parameter int XLEN     = E203_XLEN,
  parameter int RFIDX_W  = E203_RFIDX_WIDTH,
  parameter int BXX_BTFN = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_valid,
  output logic                       i_ready,
  input  logic [31:0]                i_instr,
  input  logic [PC_W-1:0]            i_pc,
  input  logic                       flush,
  output logic                       o_valid,
  input  logic                       o_ready,
  output logic [31:0]                o_instr,
  output logic [PC_W-1:0]            o_pc,
  output logic                       o_rv32,
  output logic                       o_bjp,
  output logic                       o_jal,
  output logic                       o_jalr,
  output logic                       o_bxx,
  output logic [RFIDX_W-1:0]         o_jalr_rs1idx,
  output logic [XLEN-1:0]            o_bjp_imm,
  output logic                       o_prdt_taken,
  output logic [PC_W-1:0]            o_prdt_pc,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          wr_en, rd_en;

  logic               d_rv32, d_jal, d_jalr, d_bxx, d_taken;
  logic [RFIDX_W-1:0] d_rs1idx;
  logic [XLEN-1:0]    d_imm;
  logic [PC_W-1:0]    d_prdt_pc;

  logic [31:0]        instr_q  [DEPTH];
  logic [PC_W-1:0]    pc_q     [DEPTH];
  logic               rv32_q   [DEPTH];
  logic               jal_q    [DEPTH];
  logic               jalr_q   [DEPTH];
  logic               bxx_q    [DEPTH];
  logic [RFIDX_W-1:0] rs1idx_q [DEPTH];
  logic [XLEN-1:0]    imm_q    [DEPTH];
  logic               taken_q  [DEPTH];
  logic [PC_W-1:0]    ppc_q    [DEPTH];

  e203_ifu_predec_core #(
    .PC_W     (PC_W),
    .XLEN     (XLEN),
    .RFIDX_W  (RFIDX_W),
    .BXX_BTFN (BXX_BTFN)
  ) u_core (
    .instr_i      (i_instr),
    .pc_i         (i_pc),
    .rv32_o       (d_rv32),
    .jal_o        (d_jal),
    .jalr_o       (d_jalr),
    .bxx_o        (d_bxx),
    .rs1idx_o     (d_rs1idx),
    .imm_o        (d_imm),
    .prdt_taken_o (d_taken),
    .prdt_pc_o    (d_prdt_pc)
  );

  // i_ready depends only on the registered count, never on o_ready or flush.
  assign i_ready = (cnt_q != CW'(DEPTH));
  assign o_valid = (cnt_q != '0);
  assign wr_en   = i_valid & i_ready & ~flush;
  assign rd_en   = o_valid & o_ready & ~flush;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (flush) begin
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
    end else begin
      if (wr_en) wptr_d = wptr_q + PW'(1);
      if (rd_en) rptr_d = rptr_q + PW'(1);
      case ({wr_en, rd_en})
        2'b10:   cnt_d = cnt_q + CW'(1);
        2'b01:   cnt_d = cnt_q - CW'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      instr_q[wptr_q]  <= i_instr;
      pc_q[wptr_q]     <= i_pc;
      rv32_q[wptr_q]   <= d_rv32;
      jal_q[wptr_q]    <= d_jal;
      jalr_q[wptr_q]   <= d_jalr;
      bxx_q[wptr_q]    <= d_bxx;
      rs1idx_q[wptr_q] <= d_rs1idx;
      imm_q[wptr_q]    <= d_imm;
      taken_q[wptr_q]  <= d_taken;
      ppc_q[wptr_q]    <= d_prdt_pc;
    end
  end

  assign o_instr       = instr_q[rptr_q];
  assign o_pc          = pc_q[rptr_q];
  assign o_rv32        = rv32_q[rptr_q];
  assign o_jal         = jal_q[rptr_q];
  assign o_jalr        = jalr_q[rptr_q];
  assign o_bxx         = bxx_q[rptr_q];
  assign o_bjp         = jal_q[rptr_q] | jalr_q[rptr_q] | bxx_q[rptr_q];
  assign o_jalr_rs1idx = rs1idx_q[rptr_q];
  assign o_bjp_imm     = imm_q[rptr_q];
  assign o_prdt_taken  = taken_q[rptr_q];
  assign o_prdt_pc     = ppc_q[rptr_q];
  assign o_count       = cnt_q;

endmodule

// File: tb/tb_e203_ifu_predec_fifo.sv
// Directed + randomized bench for the pre-decode buffer; a queue model with an
// arithmetic decoder supplies all expected values for a BTFN and a not-taken instance.
module tb_e203_ifu_predec_fifo;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n, i_valid, flush, o_ready;
  logic [31:0]   i_instr, i_pc;

  logic          i_ready, o_valid, o_rv32, o_bjp, o_jal, o_jalr, o_bxx, o_prdt_taken;
  logic [31:0]   o_instr, o_pc, o_bjp_imm, o_prdt_pc;
  logic [4:0]    o_jalr_rs1idx;
  logic [CW-1:0] o_count;

  logic          i_ready_b, o_valid_b, o_rv32_b, o_bjp_b, o_jal_b, o_jalr_b, o_bxx_b, o_prdt_taken_b;
  logic [31:0]   o_instr_b, o_pc_b, o_bjp_imm_b, o_prdt_pc_b;
  logic [4:0]    o_jalr_rs1idx_b;
  logic [CW-1:0] o_count_b;

  always #5 clk = ~clk;

  e203_ifu_predec_fifo #(.DEPTH(DEPTH), .BXX_BTFN(1)) dut (
    .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .i_ready(i_ready), .i_instr(i_instr),
    .i_pc(i_pc), .flush(flush), .o_valid(o_valid), .o_ready(o_ready), .o_instr(o_instr),
    .o_pc(o_pc), .o_rv32(o_rv32), .o_bjp(o_bjp), .o_jal(o_jal), .o_jalr(o_jalr),
    .o_bxx(o_bxx), .o_jalr_rs1idx(o_jalr_rs1idx), .o_bjp_imm(o_bjp_imm),
    .o_prdt_taken(o_prdt_taken), .o_prdt_pc(o_prdt_pc), .o_count(o_count)
  );

  e203_ifu_predec_fifo #(.DEPTH(DEPTH), .BXX_BTFN(0)) dut_nt (
    .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .i_ready(i_ready_b), .i_instr(i_instr),
    .i_pc(i_pc), .flush(flush), .o_valid(o_valid_b), .o_ready(o_ready), .o_instr(o_instr_b),
    .o_pc(o_pc_b), .o_rv32(o_rv32_b), .o_bjp(o_bjp_b), .o_jal(o_jal_b), .o_jalr(o_jalr_b),
    .o_bxx(o_bxx_b), .o_jalr_rs1idx(o_jalr_rs1idx_b), .o_bjp_imm(o_bjp_imm_b),
    .o_prdt_taken(o_prdt_taken_b), .o_prdt_pc(o_prdt_pc_b), .o_count(o_count_b)
  );

  typedef struct { logic [31:0] instr; logic [31:0] pc; } ent_t;
  typedef struct {
    bit rv32; bit jal; bit jalr; bit bxx; logic [4:0] rs1;
    logic [31:0] imm; bit taken; logic [31:0] ppc;
  } exp_t;

  ent_t mq[$];
  int   n_total = 0;
  int   n_pass  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic longint fld(input logic [31:0] x, input int hi, input int lo);
    return (longint'(x) >> lo) & ((longint'(1) << (hi - lo + 1)) - 1);
  endfunction

  // Offsets are rebuilt as weighted sums of instruction fields; the sign bit carries a negative weight.
  function automatic exp_t predict(input ent_t e, input bit btfn);
    exp_t   r;
    longint off;
    longint q, f3, op;
    logic [31:0] x;
    x   = e.instr;
    off = 0;
    r   = '{default: 0};
    q   = fld(x, 1, 0);
    f3  = fld(x, 15, 13);
    op  = fld(x, 6, 0);
    r.rv32 = (q == 3);
    if (r.rv32) begin
      if (op == 'h6F) begin
        r.jal = 1;
        off = -fld(x, 31, 31) * (longint'(1) << 20) + fld(x, 19, 12) * 4096
              + fld(x, 20, 20) * 2048 + fld(x, 30, 21) * 2;
      end else if (op == 'h67) begin
        r.jalr = 1;
        r.rs1  = 5'(fld(x, 19, 15));
      end else if (op == 'h63) begin
        r.bxx = 1;
        off = -fld(x, 31, 31) * 4096 + fld(x, 7, 7) * 2048 + fld(x, 30, 25) * 32 + fld(x, 11, 8) * 2;
      end
    end else if (q == 1) begin
      if (f3 == 5 || f3 == 1) begin
        r.jal = 1;
        off = -fld(x, 12, 12) * 2048 + fld(x, 11, 11) * 16 + fld(x, 10, 9) * 256 + fld(x, 8, 8) * 1024
              + fld(x, 7, 7) * 64 + fld(x, 6, 6) * 128 + fld(x, 5, 3) * 2 + fld(x, 2, 2) * 32;
      end else if (f3 >= 6) begin
        r.bxx = 1;
        off = -fld(x, 12, 12) * 256 + fld(x, 11, 10) * 8 + fld(x, 6, 5) * 64
              + fld(x, 4, 3) * 2 + fld(x, 2, 2) * 32;
      end
    end else if (q == 2 && f3 == 4 && fld(x, 6, 2) == 0 && fld(x, 11, 7) != 0) begin
      r.jalr = 1;
      r.rs1  = 5'(fld(x, 11, 7));
    end
    r.imm   = 32'(off);
    r.taken = r.jal || (r.bxx && btfn && off < 0);
    r.ppc   = r.taken ? 32'(longint'(e.pc) + off) : 32'(longint'(e.pc) + (r.rv32 ? 4 : 2));
    return r;
  endfunction

  task automatic check_state();
    exp_t a, b;
    chk("o_valid", o_valid, mq.size() != 0);
    chk("i_ready", i_ready, mq.size() != DEPTH);
    chk("o_count", o_count, mq.size());
    chk("o_count_nt", o_count_b, mq.size());
    if (mq.size() != 0) begin
      a = predict(mq[0], 1'b1);
      b = predict(mq[0], 1'b0);
      chk("o_instr", a.rv32 ? o_instr : {16'h0, o_instr[15:0]},
          a.rv32 ? mq[0].instr : {16'h0, mq[0].instr[15:0]});
      chk("o_pc", o_pc, mq[0].pc);
      chk("o_rv32", o_rv32, a.rv32);
      chk("o_bjp", o_bjp, a.jal | a.jalr | a.bxx);
      chk("o_jal", o_jal, a.jal);
      chk("o_jalr", o_jalr, a.jalr);
      chk("o_bxx", o_bxx, a.bxx);
      if (a.jalr) chk("o_jalr_rs1idx", o_jalr_rs1idx, a.rs1);
      chk("o_bjp_imm", o_bjp_imm, a.imm);
      chk("o_prdt_taken", o_prdt_taken, a.taken);
      chk("o_prdt_pc", o_prdt_pc, a.ppc);
      chk("o_prdt_taken_nt", o_prdt_taken_b, b.taken);
      chk("o_prdt_pc_nt", o_prdt_pc_b, b.ppc);
    end
  endtask

  // Inputs are set before the call; the model applies the handshake seen at this edge.
  task automatic step();
    bit wr, rd;
    wr = i_valid && (mq.size() != DEPTH);
    rd = o_ready && (mq.size() != 0);
    @(posedge clk);
    #1;
    if (flush) mq.delete();
    else begin
      if (rd) void'(mq.pop_front());
      if (wr) mq.push_back('{i_instr, i_pc});
    end
    check_state();
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 8))
      0: r[6:0] = 7'h6F;
      1: r[6:0] = 7'h67;
      2: r[6:0] = 7'h63;
      3: r[1:0] = 2'b11;
      4: begin r[1:0] = 2'b01; r[15:13] = 3'b101; end
      5: begin r[1:0] = 2'b01; r[15:13] = 3'b001; end
      6: begin r[1:0] = 2'b01; r[15:14] = 2'b11; end
      7: begin r[1:0] = 2'b10; r[15:13] = 3'b100; r[6:2] = 5'd0; end
      default: r[1:0] = 2'($urandom_range(0, 2));
    endcase
    return r;
  endfunction

  function automatic logic [31:0] rand_pc();
    if ($urandom_range(0, 7) == 0) return 32'hFFFF_FFF0 + 32'($urandom_range(0, 7) * 2);
    return $urandom & 32'hFFFF_FFFE;
  endfunction

  task automatic rand_cycles(input int n);
    for (int k = 0; k < n; k++) begin
      i_valid = 1'($urandom_range(0, 1));
      o_ready = 1'($urandom_range(0, 1));
      flush   = ($urandom_range(0, 24) == 0);
      i_instr = rand_instr();
      i_pc    = rand_pc();
      step();
    end
    flush = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; i_valid = 1'b0; i_instr = '0; i_pc = '0; flush = 1'b0; o_ready = 1'b0;
    #12;
    chk("rst_o_valid", o_valid, 0);
    chk("rst_i_ready", i_ready, 1);
    chk("rst_o_count", o_count, 0);
    @(negedge clk) rst_n = 1'b1;

    i_valid = 1'b1; i_instr = 32'h0080_006F; i_pc = 32'h100; step(); i_valid = 1'b0;
    chk("jal_o_valid", o_valid, 1);
    chk("jal_o_jal", o_jal, 1);
    chk("jal_imm", o_bjp_imm, 32'd8);
    chk("jal_taken", o_prdt_taken, 1);
    chk("jal_prdt_pc", o_prdt_pc, 32'h108);
    o_ready = 1'b1; step(); o_ready = 1'b0;

    i_valid = 1'b1; i_instr = 32'hFE00_0EE3; i_pc = 32'h200; step(); i_valid = 1'b0;
    chk("beq_taken", o_prdt_taken, 1);
    chk("beq_prdt_pc", o_prdt_pc, 32'h1FC);
    chk("beq_nt_taken", o_prdt_taken_b, 0);
    chk("beq_nt_prdt_pc", o_prdt_pc_b, 32'h204);
    o_ready = 1'b1; step(); o_ready = 1'b0;

    i_valid = 1'b1; i_instr = 32'h0000_0001; i_pc = 32'h300; step();
    i_instr = 32'h0000_8282; i_pc = 32'h302; step(); i_valid = 1'b0;
    chk("cnop_rv32", o_rv32, 0);
    chk("cnop_bjp", o_bjp, 0);
    chk("cnop_prdt_pc", o_prdt_pc, 32'h302);
    o_ready = 1'b1; step();
    chk("cjr_jalr", o_jalr, 1);
    chk("cjr_rs1", o_jalr_rs1idx, 5);
    chk("cjr_taken", o_prdt_taken, 0);
    step(); o_ready = 1'b0;

    i_valid = 1'b1;
    for (int k = 0; k < DEPTH + 2 && i_ready; k++) begin
      i_instr = rand_instr(); i_pc = rand_pc(); step();
    end
    chk("fill_i_ready", i_ready, 0);
    chk("fill_count", o_count, DEPTH);

    o_ready = 1'b1; i_instr = rand_instr(); i_pc = rand_pc(); step();
    chk("full_rd_count", o_count, DEPTH - 1);
    for (int k = 0; k < 2 * DEPTH + 1; k++) begin
      i_instr = rand_instr(); i_pc = rand_pc(); step();
      chk("rw_count_hold", o_count, DEPTH - 1);
    end
    i_valid = 1'b0;
    repeat (DEPTH + 1) step();

    rand_cycles(300);
    i_valid = 1'b0; o_ready = 1'b1;
    repeat (DEPTH + 1) step();

    o_ready = 1'b0; i_valid = 1'b1;
    repeat (3) begin i_instr = rand_instr(); i_pc = rand_pc(); step(); end
    chk("pre_flush_count", o_count, 3);
    flush = 1'b1; i_instr = 32'hDEAD_0013; i_pc = 32'h0BAD_0000; step(); flush = 1'b0;
    chk("flush_o_valid", o_valid, 0);
    chk("flush_count", o_count, 0);
    i_instr = 32'h0000_0001; i_pc = 32'h400; step(); i_valid = 1'b0;
    chk("post_flush_pc", o_pc, 32'h400);
    chk("post_flush_count", o_count, 1);

    i_valid = 1'b1; i_instr = rand_instr(); i_pc = rand_pc(); step(); i_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_o_valid", o_valid, 0);
    chk("arst_i_ready", i_ready, 1);
    chk("arst_count", o_count, 0);
    mq.delete();
    @(negedge clk) rst_n = 1'b1;
    rand_cycles(60);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
